// File: rtl/interrupt_controller.sv
// Interrupt controller: latches watchdog and I/O requests, enters the handler at an
// instruction boundary, holds special mode while it runs and hands the saved PC back on return.
module interrupt_controller #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] HANDLER_BASE = 32'h0000_0100
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  interruption,
    input  logic                  io_interrupt,
    input  logic                  interrupt_enable,
    input  logic                  instruction_boundary,
    input  logic [ADDR_WIDTH-1:0] current_pc,
    input  logic                  return_from_interrupt,
    output logic                  is_special_mode,
    output logic                  take_interrupt,
    output logic [ADDR_WIDTH-1:0] handler_address,
    output logic                  restore_pc,
    output logic [ADDR_WIDTH-1:0] saved_pc,
    output logic                  cause,
    output logic [1:0]            pending
);

    typedef enum logic [2:0] {
        IDLE,
        PENDING,
        ENTER,
        SPECIAL,
        EXIT
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic                    accept;
    logic                    select_io;
    logic [1:0]              pending_next;
    logic [ADDR_WIDTH-1:0]   vector_offset;

    assign accept        = (state == PENDING) && interrupt_enable && instruction_boundary;
    assign select_io     = !pending[0];
    assign vector_offset = ADDR_WIDTH'({select_io, 2'b00});

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (|pending) state_next = PENDING;
            PENDING: if (accept) state_next = ENTER;
            ENTER:   state_next = SPECIAL;
            SPECIAL: if (return_from_interrupt) state_next = EXIT;
            EXIT:    state_next = (|pending) ? PENDING : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A new request in the same cycle as its clear wins, so the OR is applied last.
    always_comb begin
        pending_next = pending;
        if (accept) begin
            if (select_io) pending_next[1] = 1'b0;
            else           pending_next[0] = 1'b0;
        end
        pending_next = pending_next | {io_interrupt, interruption};
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state           <= IDLE;
            pending         <= 2'b00;
            cause           <= 1'b0;
            saved_pc        <= '0;
            handler_address <= '0;
        end else begin
            state   <= state_next;
            pending <= pending_next;
            if (accept) begin
                cause           <= select_io;
                saved_pc        <= current_pc;
                handler_address <= HANDLER_BASE + vector_offset;
            end
        end
    end

    assign take_interrupt  = (state == ENTER);
    assign restore_pc      = (state == EXIT);
    assign is_special_mode = (state == ENTER) || (state == SPECIAL) || (state == EXIT);

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: directed scenarios followed by
// randomized traffic compared against a cycle-level behavioural model.
module tb_interrupt_controller;

    localparam logic [31:0] BASE = 32'h0000_0100;

    logic        clock;
    logic        reset;
    logic        interruption;
    logic        io_interrupt;
    logic        interrupt_enable;
    logic        instruction_boundary;
    logic [31:0] current_pc;
    logic        return_from_interrupt;
    logic        is_special_mode;
    logic        take_interrupt;
    logic [31:0] handler_address;
    logic        restore_pc;
    logic [31:0] saved_pc;
    logic        cause;
    logic [1:0]  pending;

    int tests_run    = 0;
    int tests_failed = 0;

    // Model: pending flags plus which phase of the handler sequence is underway.
    logic        m_wd, m_io, m_armed, m_enter, m_handler, m_exit, m_cause;
    logic [31:0] m_haddr, m_saved;

    interrupt_controller #(.ADDR_WIDTH(32), .HANDLER_BASE(BASE)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .interruption          (interruption),
        .io_interrupt          (io_interrupt),
        .interrupt_enable      (interrupt_enable),
        .instruction_boundary  (instruction_boundary),
        .current_pc            (current_pc),
        .return_from_interrupt (return_from_interrupt),
        .is_special_mode       (is_special_mode),
        .take_interrupt        (take_interrupt),
        .handler_address       (handler_address),
        .restore_pc            (restore_pc),
        .saved_pc              (saved_pc),
        .cause                 (cause),
        .pending               (pending)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic intr, input logic io, input logic ie,
                                 input logic ib, input logic rfi, input logic [31:0] pc);
        interruption          = intr;
        io_interrupt          = io;
        interrupt_enable      = ie;
        instruction_boundary  = ib;
        return_from_interrupt = rfi;
        current_pc            = pc;
    endtask

    // Called in the ENTER cycle; walks SPECIAL -> EXIT -> next state.
    task automatic run_handler_out();
        instruction_boundary  = 1'b0;
        return_from_interrupt = 1'b0;
        tick();
        return_from_interrupt = 1'b1;
        tick();
        return_from_interrupt = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        reset = 1'b0;
        tick();
        tick();
        tests_run++;
        if ({is_special_mode, take_interrupt, restore_pc, cause, pending} !== 6'b0 ||
            handler_address !== 32'h0 || saved_pc !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_state: got s/t/r/c/p=%b ha=%h spc=%h, expected all zero",
                     {is_special_mode, take_interrupt, restore_pc, cause, pending},
                     handler_address, saved_pc);
        end
        reset = 1'b1;
    endtask

    task automatic test_watchdog_entry();
        interruption = 1'b1;
        tick();
        interruption = 1'b0;
        tests_run++;
        if (pending !== 2'b01 || take_interrupt !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL wd_latch: pending=%b take=%b, expected 01/0", pending, take_interrupt);
        end
        interrupt_enable     = 1'b1;
        instruction_boundary = 1'b1;
        current_pc           = 32'h200;
        tick();
        tests_run++;
        if ({is_special_mode, take_interrupt} !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL wd_no_entry_from_idle: s/t=%b, expected 00",
                     {is_special_mode, take_interrupt});
        end
        tick();
        tests_run++;
        if ({is_special_mode, take_interrupt, restore_pc} !== 3'b110 || pending !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL wd_enter: s/t/r=%b pending=%b, expected 110/00",
                     {is_special_mode, take_interrupt, restore_pc}, pending);
        end
        tests_run++;
        if (handler_address !== 32'h100 || saved_pc !== 32'h200 || cause !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL wd_vector: ha=%h spc=%h cause=%b, expected 100/200/0",
                     handler_address, saved_pc, cause);
        end
        instruction_boundary = 1'b0;
        current_pc           = 32'h300;
        tick();
        tests_run++;
        if ({is_special_mode, take_interrupt} !== 2'b10 || saved_pc !== 32'h200) begin
            tests_failed++;
            $display("[TB] FAIL wd_special: s/t=%b spc=%h, expected 10/200",
                     {is_special_mode, take_interrupt}, saved_pc);
        end
    endtask

    task automatic test_handler_return();
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++;
            if ({is_special_mode, take_interrupt, restore_pc} !== 3'b100) begin
                tests_failed++;
                $display("[TB] FAIL handler_hold[%0d]: s/t/r=%b, expected 100", i,
                         {is_special_mode, take_interrupt, restore_pc});
            end
        end
        return_from_interrupt = 1'b1;
        tick();
        tests_run++;
        if ({is_special_mode, take_interrupt, restore_pc} !== 3'b101) begin
            tests_failed++;
            $display("[TB] FAIL handler_exit: s/t/r=%b, expected 101",
                     {is_special_mode, take_interrupt, restore_pc});
        end
        return_from_interrupt = 1'b0;
        tick();
        tests_run++;
        if ({is_special_mode, take_interrupt, restore_pc} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL handler_idle: s/t/r=%b, expected 000",
                     {is_special_mode, take_interrupt, restore_pc});
        end
        return_from_interrupt = 1'b1;
        tick();
        tests_run++;
        if ({is_special_mode, restore_pc} !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL rfi_outside_special: s/r=%b, expected 00",
                     {is_special_mode, restore_pc});
        end
        return_from_interrupt = 1'b0;
    endtask

    task automatic test_simultaneous();
        interruption = 1'b1;
        io_interrupt = 1'b1;
        tick();
        interruption = 1'b0;
        io_interrupt = 1'b0;
        tests_run++;
        if (pending !== 2'b11) begin
            tests_failed++;
            $display("[TB] FAIL both_latch: pending=%b, expected 11", pending);
        end
        interrupt_enable     = 1'b1;
        instruction_boundary = 1'b1;
        current_pc           = 32'h400;
        tick();
        tick();
        tests_run++;
        if (take_interrupt !== 1'b1 || handler_address !== 32'h100 || cause !== 1'b0 ||
            pending !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL both_wd_first: t=%b ha=%h c=%b p=%b, expected 1/100/0/10",
                     take_interrupt, handler_address, cause, pending);
        end
        instruction_boundary = 1'b0;
        tick();
        return_from_interrupt = 1'b1;
        tick();
        return_from_interrupt = 1'b0;
        tick();
        tests_run++;
        if ({is_special_mode, take_interrupt} !== 2'b00 || pending !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL both_after_exit: s/t=%b p=%b, expected 00/10",
                     {is_special_mode, take_interrupt}, pending);
        end
        instruction_boundary = 1'b1;
        current_pc           = 32'h440;
        tick();
        tests_run++;
        if (take_interrupt !== 1'b1 || handler_address !== 32'h104 || cause !== 1'b1 ||
            saved_pc !== 32'h440 || pending !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL both_io_second: t=%b ha=%h c=%b spc=%h p=%b, expected 1/104/1/440/00",
                     take_interrupt, handler_address, cause, saved_pc, pending);
        end
        run_handler_out();
    endtask

    task automatic test_queued_io();
        interruption         = 1'b1;
        interrupt_enable     = 1'b1;
        instruction_boundary = 1'b1;
        tick();
        interruption = 1'b0;
        tick();
        tick();
        instruction_boundary = 1'b0;
        tick();
        io_interrupt = 1'b1;
        tick();
        io_interrupt         = 1'b0;
        instruction_boundary = 1'b1;
        tests_run++;
        if (pending !== 2'b10 || take_interrupt !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL queued_latch: p=%b t=%b, expected 10/0", pending, take_interrupt);
        end
        tick();
        tick();
        tests_run++;
        if ({is_special_mode, take_interrupt} !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL queued_no_nest: s/t=%b, expected 10",
                     {is_special_mode, take_interrupt});
        end
        return_from_interrupt = 1'b1;
        tick();
        return_from_interrupt = 1'b0;
        tick();
        tests_run++;
        if (take_interrupt !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL queued_pending_cycle: t=%b, expected 0", take_interrupt);
        end
        tick();
        tests_run++;
        if (take_interrupt !== 1'b1 || handler_address !== 32'h104 || cause !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL queued_io_enter: t=%b ha=%h c=%b, expected 1/104/1",
                     take_interrupt, handler_address, cause);
        end
        run_handler_out();
    endtask

    task automatic test_enable_gate();
        interrupt_enable = 1'b0;
        interruption     = 1'b1;
        tick();
        interruption         = 1'b0;
        instruction_boundary = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            tests_run++;
            if ({is_special_mode, take_interrupt} !== 2'b00) begin
                tests_failed++;
                $display("[TB] FAIL enable_gate[%0d]: s/t=%b, expected 00", i,
                         {is_special_mode, take_interrupt});
            end
        end
        interrupt_enable = 1'b1;
        tick();
        tests_run++;
        if (take_interrupt !== 1'b1 || pending !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL enable_release: t=%b p=%b, expected 1/00", take_interrupt, pending);
        end
        run_handler_out();
    endtask

    task automatic test_io_level();
        io_interrupt         = 1'b1;
        interrupt_enable     = 1'b1;
        instruction_boundary = 1'b1;
        tick();
        tick();
        tick();
        tests_run++;
        if (take_interrupt !== 1'b1 || cause !== 1'b1 || pending !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL level_set_wins: t=%b c=%b p=%b, expected 1/1/10",
                     take_interrupt, cause, pending);
        end
        io_interrupt         = 1'b0;
        instruction_boundary = 1'b0;
        tick();
        return_from_interrupt = 1'b1;
        tick();
        return_from_interrupt = 1'b0;
        tick();
        tests_run++;
        if (is_special_mode !== 1'b0 || cause !== 1'b1 || pending !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL level_repend: s=%b c=%b p=%b, expected 0/1/10",
                     is_special_mode, cause, pending);
        end
        instruction_boundary = 1'b1;
        tick();
        tests_run++;
        if (take_interrupt !== 1'b1 || handler_address !== 32'h104) begin
            tests_failed++;
            $display("[TB] FAIL level_reentry: t=%b ha=%h, expected 1/104", take_interrupt, handler_address);
        end
        run_handler_out();
    endtask

    task automatic test_reset_in_handler();
        interruption         = 1'b1;
        interrupt_enable     = 1'b1;
        instruction_boundary = 1'b1;
        current_pc           = 32'h0000_0abc;
        tick();
        interruption = 1'b0;
        tick();
        tick();
        instruction_boundary = 1'b0;
        tick();
        io_interrupt = 1'b1;
        tick();
        io_interrupt = 1'b0;
        interruption = 1'b1;
        reset        = 1'b0;
        tick();
        interruption = 1'b0;
        tests_run++;
        if ({is_special_mode, take_interrupt, restore_pc, cause, pending} !== 6'b0 ||
            handler_address !== 32'h0 || saved_pc !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL midhandler_reset: s/t/r/c/p=%b ha=%h spc=%h, expected all zero",
                     {is_special_mode, take_interrupt, restore_pc, cause, pending},
                     handler_address, saved_pc);
        end
        reset                 = 1'b1;
        return_from_interrupt = 1'b1;
        tick();
        tick();
        tests_run++;
        if ({is_special_mode, restore_pc} !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL post_reset_rfi: s/r=%b, expected 00", {is_special_mode, restore_pc});
        end
        return_from_interrupt = 1'b0;
    endtask

    task automatic model_reset();
        {m_wd, m_io, m_armed, m_enter, m_handler, m_exit, m_cause} = 7'b0;
        m_haddr = 32'h0;
        m_saved = 32'h0;
    endtask

    task automatic model_step(input logic intr, input logic io, input logic ie,
                              input logic ib, input logic rfi, input logic [31:0] pc);
        logic any, idle, accept, take_wd;
        logic n_armed, n_enter, n_handler, n_exit;
        any     = m_wd | m_io;
        idle    = !(m_armed | m_enter | m_handler | m_exit);
        accept  = m_armed && ie && ib;
        take_wd = m_wd;
        if (accept) begin
            m_cause = !take_wd;
            m_saved = pc;
            m_haddr = BASE + (take_wd ? 32'd0 : 32'd4);
        end
        n_armed   = ((idle || m_exit) && any) || (m_armed && !accept);
        n_enter   = accept;
        n_handler = m_enter || (m_handler && !rfi);
        n_exit    = m_handler && rfi;
        m_wd      = (m_wd && !(accept && take_wd)) || intr;
        m_io      = (m_io && !(accept && !take_wd)) || io;
        m_armed   = n_armed;
        m_enter   = n_enter;
        m_handler = n_handler;
        m_exit    = n_exit;
    endtask

    task automatic test_random();
        logic        r_rst, r_intr, r_io, r_ie, r_ib, r_rfi, io_level;
        logic [31:0] r_pc;
        logic [69:0] expected, actual;
        int          shown;
        shown    = 0;
        io_level = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        reset = 1'b0;
        tick();
        model_reset();
        reset = 1'b1;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if ($urandom_range(0, 19) == 0) io_level = !io_level;
            r_rst  = ($urandom_range(0, 99) == 0);
            r_intr = ($urandom_range(0, 11) == 0);
            r_io   = io_level || ($urandom_range(0, 14) == 0);
            r_ie   = ($urandom_range(0, 3) != 0);
            r_ib   = $urandom_range(0, 1) == 1;
            r_rfi  = ($urandom_range(0, 4) == 0);
            r_pc   = $urandom & 32'hffff_fffc;
            applyStimulus(r_intr, r_io, r_ie, r_ib, r_rfi, r_pc);
            reset = !r_rst;
            if (r_rst) model_reset();
            else model_step(r_intr, r_io, r_ie, r_ib, r_rfi, r_pc);
            tick();
            expected = {m_enter | m_handler | m_exit, m_enter, m_exit, m_cause,
                        m_io, m_wd, m_haddr, m_saved};
            actual   = {is_special_mode, take_interrupt, restore_pc, cause,
                        pending, handler_address, saved_pc};
            tests_run++;
            if (actual !== expected) begin
                tests_failed++;
                if (shown < 10) begin
                    shown++;
                    $display("[TB] FAIL random_cycle %0d: got %h expected %h", cyc, actual, expected);
                end
            end
        end
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        test_reset();
        test_watchdog_entry();
        test_handler_return();
        test_simultaneous();
        test_queued_io();
        test_enable_gate();
        test_io_level();
        test_reset_in_handler();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
